lpm_hint_evaluator: RTL and testbench
=====================================

Name: lpm_hint_evaluator

Overview:
- Byte-serial, clocked evaluator for LPM hint strings of the form "NAME=VALUE,NAME=VALUE,...".
- Extracts the value of one selected parameter, substitutes the default when the parameter is absent, and validates the result.
- For INTENDED_DEVICE_FAMILY it also classifies the family: valid, Stratix-based, Cyclone-based.
- Sits in front of LPM-style FIFO/RAM wrappers that need their configuration decoded at setup time.

Parameters:
- MAX_VAL_LEN, 24: maximum stored value length in characters; val output is 8*MAX_VAL_LEN bits.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- aclr_n  in  1  asynchronous reset, active low.
- start  in  1  pulse; latches key_sel and clears all parse state.
- key_sel  in  2  0=OVERFLOW_CHECKING, 1=UNDERFLOW_CHECKING, 2=ALLOW_RWCYCLE_WHEN_FULL, 3=INTENDED_DEVICE_FAMILY.
- char_valid  in  1  hint_char is valid this cycle; one character per cycle, no backpressure.
- hint_char  in  8  ASCII hint character.
- hint_end  in  1  pulse after the last character; never coincident with char_valid or start.
- busy  out  1  high from start until done.
- done  out  1  one-cycle pulse; results are valid from this cycle and held until the next start.
- found  out  1  selected name was present in the hint.
- val  out  8*MAX_VAL_LEN  resulting value as a Verilog-style string: last character in bits [7:0], unused upper bytes zero.
- val_len  out  $clog2(MAX_VAL_LEN+1)  number of characters in val.
- err  out  1  invalid value, or value truncated.
- fam_valid, fam_stratix, fam_cyclone  out  1 each  family classification; valid only when key_sel=3.

Behaviour:
- Reset: all outputs and internal state are 0. busy=0.
- Operation outside a session:
  - char_valid and hint_end are ignored while busy=0.
  - start while busy restarts the session; no done is produced for the aborted session.
- Tokenising:
  - ',' ends a pair.
  - The first '=' in a pair splits name from value.
  - Spaces before the name and before the value are skipped. Embedded and trailing spaces in the value are kept.
  - A pair with no '=' is ignored.
- Name matching:
  - Matching is case-insensitive and requires the exact full length of the name.
  - If the name appears more than once, the first occurrence wins; later occurrences are ignored.
- Value capture:
  - The value is stored as received, preserving case.
  - If the value is longer than MAX_VAL_LEN, the first MAX_VAL_LEN characters are kept and err=1.
- Completion:
  - hint_end at cycle N produces done=1 and busy=0 at cycle N+1.
  - An empty hint (start then hint_end) is legal.
- Defaults when found=0: key 0 -> "ON", key 1 -> "ON", key 2 -> "OFF", key 3 -> "Stratix II". err=0 in all default cases.
- Validation, keys 0-2: err=1 unless the value case-insensitively equals "ON" or "OFF". An empty value is an error.
- Family classification, key 3:
  - Comparison is case-insensitive and ignores trailing spaces.
  - Known families: Stratix, Stratix GX, Stratix II, Stratix II GX, Stratix III, Stratix IV, Stratix V, Cyclone, Cyclone II, Cyclone III, Cyclone IV E, Cyclone IV GX, Cyclone V, Arria GX, Arria II GX, MAX 10.
  - fam_valid=1 when the value is in the known list.
  - fam_stratix=1 when the value is valid and begins with "Stratix".
  - fam_cyclone=1 when the value is valid and begins with "Cyclone".
  - err = !fam_valid.
  - For keys 0-2, all fam_* outputs are 0.
- Asynchronous reset mid-session aborts it immediately; no done is produced.

Optional Feature:
- Macro: LPM_HINT_FAMILY_CHECK_EN.
- Defined: family classification and family validation are exactly as specified above.
- Undefined:
  - The family table is not built.
  - fam_valid=1, fam_stratix=0 and fam_cyclone=0 whenever key_sel=3; all three are 0 for keys 0-2.
  - err for key 3 is set only on truncation.

Test Plan:
- key 0, hint "OVERFLOW_CHECKING=OFF" -> done 1 cycle after hint_end; found=1, val="OFF", val_len=3, err=0.
- key 3, empty hint -> found=0, val="Stratix II", fam_valid=1, fam_stratix=1, fam_cyclone=0, err=0.
- key 3, hint " underflow_checking=ON , intended_device_family=cyclone v" -> val="cyclone v", fam_cyclone=1, fam_stratix=0, err=0.
- key 1, hint "UNDERFLOW_CHECKING=MAYBE,UNDERFLOW_CHECKING=ON" -> first occurrence wins: val="MAYBE", err=1.
- key 3, value "Foo 9000" -> fam_valid=0, err=1; with MAX_VAL_LEN=4 and value "Stratix II" -> val="Stra", err=1.
- Pulse aclr_n low mid-hint, then start/hint "ALLOW_RWCYCLE_WHEN_FULL=ON" with key 2 -> no done from the aborted session; second session gives val="ON", found=1.

Source files
------------

// File: rtl/lpm_hint_evaluator.sv
// Byte-serial evaluator for "NAME=VALUE,..." LPM hint strings: extracts one parameter,
// applies its default and validates it. Define LPM_HINT_FAMILY_CHECK_EN to build the family table.
module lpm_hint_evaluator #(
    parameter  int MAX_VAL_LEN = 24,
    localparam int LW = $clog2(MAX_VAL_LEN + 1),
    localparam int VW = 8 * MAX_VAL_LEN
) (
    input  logic          clock,
    input  logic          aclr_n,
    input  logic          start,
    input  logic [1:0]    key_sel,
    input  logic          char_valid,
    input  logic [7:0]    hint_char,
    input  logic          hint_end,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic [VW-1:0] val,
    output logic [LW-1:0] val_len,
    output logic          err,
    output logic          fam_valid,
    output logic          fam_stratix,
    output logic          fam_cyclone
);
    // working width in bytes: wide enough for the value and the longest family/default string
    localparam int FW = (MAX_VAL_LEN > 13) ? MAX_VAL_LEN : 13;

    typedef enum logic [2:0] {P_LEAD, P_NAME, P_VLEAD, P_VALUE, P_SKIP} phase_t;

    phase_t        phase_q, phase_d;
    logic [1:0]    key_q;
    logic [4:0]    idx_q, idx_base;
    logic          name_ok_q, found_q, trunc_q;
    logic [VW-1:0] val_q;
    logic [LW-1:0] len_q;
    logic          act, is_sp, is_comma, is_eq;
    logic          name_step, name_hit, store;

    function automatic logic [7:0] upc(input logic [7:0] c);
        return (c >= "a" && c <= "z") ? c - 8'd32 : c;
    endfunction

    function automatic logic [4:0] name_len(input logic [1:0] k);
        case (k)
            2'd0:    return 5'd17;
            2'd1:    return 5'd18;
            2'd2:    return 5'd23;
            default: return 5'd22;
        endcase
    endfunction

    function automatic logic [7:0] name_char(input logic [1:0] k, input logic [4:0] i);
        logic [8*23-1:0] s;
        int              l;
        case (k)
            2'd0:    s = "OVERFLOW_CHECKING";
            2'd1:    s = "UNDERFLOW_CHECKING";
            2'd2:    s = "ALLOW_RWCYCLE_WHEN_FULL";
            default: s = "INTENDED_DEVICE_FAMILY";
        endcase
        l = int'(name_len(k));
        return (int'(i) < l) ? s[8*(l-1-int'(i)) +: 8] : 8'h00;
    endfunction

    assign act      = busy && char_valid && !start;
    assign is_sp    = (hint_char == " ");
    assign is_comma = (hint_char == ",");
    assign is_eq    = (hint_char == "=");
    assign idx_base = (phase_q == P_LEAD) ? 5'd0 : idx_q;

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n)    phase_q <= P_LEAD;
        else if (start) phase_q <= P_LEAD;
        else            phase_q <= phase_d;
    end

    always_comb begin
        phase_d = phase_q;
        if (act) begin
            if (is_comma) phase_d = P_LEAD;
            else begin
                case (phase_q)
                    P_LEAD:  if (!is_sp) phase_d = is_eq ? P_SKIP : P_NAME;
                    P_NAME:  if (is_eq)  phase_d = name_hit ? P_VLEAD : P_SKIP;
                    P_VLEAD: if (!is_sp) phase_d = P_VALUE;
                    default: ;
                endcase
            end
        end
    end

    // only the first full-length match opens a capture; later duplicates fall into P_SKIP
    always_comb begin
        name_step = 1'b0;
        name_hit  = 1'b0;
        store     = 1'b0;
        if (act && !is_comma) begin
            case (phase_q)
                P_LEAD:  name_step = !is_sp && !is_eq;
                P_NAME: begin
                    name_step = !is_eq;
                    name_hit  = is_eq && name_ok_q && !found_q && (idx_q == name_len(key_q));
                end
                P_VLEAD: store = !is_sp;
                P_VALUE: store = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef LPM_HINT_FAMILY_CHECK_EN
    logic [LW-1:0] tlen_q;  // length up to the last non-space character
`endif

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n || start) begin
            key_q     <= !aclr_n ? 2'd0 : key_sel;
            idx_q     <= '0;
            name_ok_q <= 1'b0;
            found_q   <= 1'b0;
            trunc_q   <= 1'b0;
            val_q     <= '0;
            len_q     <= '0;
`ifdef LPM_HINT_FAMILY_CHECK_EN
            tlen_q    <= '0;
`endif
        end else begin
            if (name_step) begin
                name_ok_q <= ((phase_q == P_LEAD) || name_ok_q) &&
                             (upc(hint_char) == name_char(key_q, idx_base));
                idx_q     <= (idx_base == 5'd31) ? idx_base : idx_base + 5'd1;
            end
            if (name_hit) found_q <= 1'b1;
            if (store) begin
                if (len_q < LW'(MAX_VAL_LEN)) begin
                    val_q <= {val_q[VW-9:0], hint_char};
                    len_q <= len_q + 1'b1;
`ifdef LPM_HINT_FAMILY_CHECK_EN
                    if (!is_sp) tlen_q <= len_q + 1'b1;
`endif
                end else begin
                    trunc_q <= 1'b1;
                end
            end
        end
    end

`ifdef LPM_HINT_FAMILY_CHECK_EN
    localparam logic [8*13-1:0] FAM_STR [16] = '{
        "STRATIX", "STRATIX GX", "STRATIX II", "STRATIX II GX", "STRATIX III", "STRATIX IV",
        "STRATIX V", "CYCLONE", "CYCLONE II", "CYCLONE III", "CYCLONE IV E", "CYCLONE IV GX",
        "CYCLONE V", "ARRIA GX", "ARRIA II GX", "MAX 10"};
    localparam int FAM_LEN [16] = '{7, 10, 10, 13, 11, 10, 9, 7, 10, 11, 12, 13, 9, 8, 11, 6};

    logic [8*FW-1:0] trim_w;
    logic [2:0]      fam_cls;  // {valid, stratix, cyclone}

    always_comb begin
        trim_w = '0;
        for (int b = 0; b < MAX_VAL_LEN; b++) trim_w[8*b +: 8] = upc(val_q[8*b +: 8]);
        trim_w  = trim_w >> (8 * (len_q - tlen_q));
        fam_cls = '0;
        for (int f = 0; f < 16; f++)
            if (int'(tlen_q) == FAM_LEN[f] && trim_w[8*13-1:0] == FAM_STR[f])
                fam_cls = {1'b1, f < 7, (f >= 7) && (f < 13)};
    end
`endif

    logic [8*FW-1:0] dflt_v;
    int              dflt_l;
    logic            onoff, res_err, res_fv, res_fs, res_fc;
    logic [VW-1:0]   res_val;
    logic [LW-1:0]   res_len;

    always_comb begin
        dflt_v = "ON";
        dflt_l = 2;
        case (key_q)
            2'd2: begin dflt_v = "OFF";        dflt_l = 3;  end
            2'd3: begin dflt_v = "Stratix II"; dflt_l = 10; end
            default: ;
        endcase
        // a default longer than the value store keeps its leading characters
        if (dflt_l > MAX_VAL_LEN) begin
            dflt_v = dflt_v >> (8 * (dflt_l - MAX_VAL_LEN));
            dflt_l = MAX_VAL_LEN;
        end
        onoff = (len_q == LW'(2) && {upc(val_q[15:8]), upc(val_q[7:0])} == "ON") ||
                (len_q == LW'(3) && {upc(val_q[23:16]), upc(val_q[15:8]), upc(val_q[7:0])} == "OFF");
        res_val = found_q ? val_q : dflt_v[VW-1:0];
        res_len = found_q ? len_q : LW'(dflt_l);
        res_err = found_q && (trunc_q || !onoff);
        res_fv  = 1'b0;
        res_fs  = 1'b0;
        res_fc  = 1'b0;
        if (key_q == 2'd3) begin
`ifdef LPM_HINT_FAMILY_CHECK_EN
            res_fv  = !found_q || fam_cls[2];
            res_fs  = !found_q || fam_cls[1];
            res_fc  = found_q && fam_cls[0];
            res_err = found_q && (trunc_q || !fam_cls[2]);
`else
            res_fv  = 1'b1;
            res_err = found_q && trunc_q;
`endif
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n || start) begin
            busy        <= aclr_n;
            done        <= 1'b0;
            found       <= 1'b0;
            val         <= '0;
            val_len     <= '0;
            err         <= 1'b0;
            fam_valid   <= 1'b0;
            fam_stratix <= 1'b0;
            fam_cyclone <= 1'b0;
        end else if (busy && hint_end) begin
            busy        <= 1'b0;
            done        <= 1'b1;
            found       <= found_q;
            val         <= res_val;
            val_len     <= res_len;
            err         <= res_err;
            fam_valid   <= res_fv;
            fam_stratix <= res_fs;
            fam_cyclone <= res_fc;
        end else begin
            done        <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lpm_hint_evaluator.sv
// Bench for lpm_hint_evaluator: string-level reference model, per-cycle output compare,
// two instances (24- and 4-character value stores) driven by the same directed hints.
module tb_lpm_hint_evaluator;
    localparam int MA = 24;
    localparam int MB = 4;

    logic       clock = 1'b0, aclr_n = 1'b0, start = 1'b0, char_valid = 1'b0, hint_end = 1'b0;
    logic [1:0] key_sel = 2'd0;
    logic [7:0] hint_char = 8'h00;

    logic busy_a, done_a, found_a, err_a, fv_a, fs_a, fc_a;
    logic busy_b, done_b, found_b, err_b, fv_b, fs_b, fc_b;
    logic [8*MA-1:0] val_a;
    logic [8*MB-1:0] val_b;
    logic [$clog2(MA+1)-1:0] len_a;
    logic [$clog2(MB+1)-1:0] len_b;

    int checks = 0, errors = 0;
    bit expect_done = 1'b0, meaningful = 1'b0;

    typedef struct {
        bit           found;
        logic [191:0] val;
        int           len;
        bit           err, fv, fs, fc;
    } exp_t;
    exp_t exp_a, exp_b;

    string NAMES [4] = '{"OVERFLOW_CHECKING", "UNDERFLOW_CHECKING", "ALLOW_RWCYCLE_WHEN_FULL",
                         "INTENDED_DEVICE_FAMILY"};
    string DEFS  [4] = '{"ON", "ON", "OFF", "Stratix II"};
`ifdef LPM_HINT_FAMILY_CHECK_EN
    string FAMS [16] = '{"Stratix", "Stratix GX", "Stratix II", "Stratix II GX", "Stratix III",
                         "Stratix IV", "Stratix V", "Cyclone", "Cyclone II", "Cyclone III",
                         "Cyclone IV E", "Cyclone IV GX", "Cyclone V", "Arria GX", "Arria II GX",
                         "MAX 10"};
`endif

    lpm_hint_evaluator #(.MAX_VAL_LEN(MA)) dut_a (
        .clock(clock), .aclr_n(aclr_n), .start(start), .key_sel(key_sel),
        .char_valid(char_valid), .hint_char(hint_char), .hint_end(hint_end),
        .busy(busy_a), .done(done_a), .found(found_a), .val(val_a), .val_len(len_a),
        .err(err_a), .fam_valid(fv_a), .fam_stratix(fs_a), .fam_cyclone(fc_a));

    lpm_hint_evaluator #(.MAX_VAL_LEN(MB)) dut_b (
        .clock(clock), .aclr_n(aclr_n), .start(start), .key_sel(key_sel),
        .char_valid(char_valid), .hint_char(hint_char), .hint_end(hint_end),
        .busy(busy_b), .done(done_b), .found(found_b), .val(val_b), .val_len(len_b),
        .err(err_b), .fam_valid(fv_b), .fam_stratix(fs_b), .fam_cyclone(fc_b));

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic string sub(input string s, input int a, input int b);
        return (b < a) ? "" : s.substr(a, b);
    endfunction

    function automatic string lstrip(input string s);
        int k = 0;
        while (k < s.len() && s[k] == " ") k++;
        return sub(s, k, s.len() - 1);
    endfunction

    function automatic string rstrip(input string s);
        int k = s.len();
        while (k > 0 && s[k-1] == " ") k--;
        return sub(s, 0, k - 1);
    endfunction

    // Reference: split on ',', take the first full-name match, default, truncate, classify.
    function automatic exp_t model(input int key, input string hs, input int maxl);
        exp_t  e;
        string pairs[$];
        string v, st, u;
        int    s = 0, eq;
        bit    trunc;
        e.found = 0; e.val = '0; e.len = 0; e.err = 0; e.fv = 0; e.fs = 0; e.fc = 0;
        for (int i = 0; i < hs.len(); i++)
            if (hs[i] == ",") begin pairs.push_back(sub(hs, s, i - 1)); s = i + 1; end
        pairs.push_back(sub(hs, s, hs.len() - 1));
        v = DEFS[key];
        foreach (pairs[p]) begin
            eq = -1;
            for (int j = pairs[p].len() - 1; j >= 0; j--) if (pairs[p][j] == "=") eq = j;
            if (eq >= 0 && !e.found && lstrip(sub(pairs[p], 0, eq - 1)).toupper() == NAMES[key]) begin
                e.found = 1;
                v = lstrip(sub(pairs[p], eq + 1, pairs[p].len() - 1));
            end
        end
        trunc = e.found && v.len() > maxl;
        st    = (v.len() > maxl) ? sub(v, 0, maxl - 1) : v;
        e.len = st.len();
        for (int k = 0; k < st.len(); k++) e.val = {e.val[183:0], st[k]};
        u = st.toupper();
        if (key < 3) e.err = e.found && (trunc || !(u == "ON" || u == "OFF"));
        else begin
`ifdef LPM_HINT_FAMILY_CHECK_EN
            if (!e.found) begin e.fv = 1; e.fs = 1; end
            else begin
                u = rstrip(st).toupper();
                foreach (FAMS[f]) if (u == FAMS[f].toupper()) e.fv = 1;
                e.fs = e.fv && u.len() >= 7 && u.substr(0, 6) == "STRATIX";
                e.fc = e.fv && u.len() >= 7 && u.substr(0, 6) == "CYCLONE";
            end
            e.err = e.found && (trunc || !e.fv);
`else
            e.fv  = 1;
            e.err = trunc;
`endif
        end
        return e;
    endfunction

    task automatic cmp_outputs();
        chk("a_busy",  192'(busy_a),  192'(0));
        chk("a_found", 192'(found_a), 192'(exp_a.found));
        chk("a_val",   192'(val_a),   exp_a.val);
        chk("a_len",   192'(len_a),   192'(exp_a.len));
        chk("a_err",   192'(err_a),   192'(exp_a.err));
        chk("a_fam",   192'({fv_a, fs_a, fc_a}), 192'({exp_a.fv, exp_a.fs, exp_a.fc}));
        chk("b_found", 192'(found_b), 192'(exp_b.found));
        chk("b_val",   192'(val_b),   exp_b.val);
        chk("b_len",   192'(len_b),   192'(exp_b.len));
        chk("b_err",   192'(err_b),   192'(exp_b.err));
        chk("b_fam",   192'({fv_b, fs_b, fc_b}), 192'({exp_b.fv, exp_b.fs, exp_b.fc}));
    endtask

    always @(negedge clock) begin
        if (done_a || done_b) begin
            checks++;
            if (!expect_done || !(done_a && done_b)) begin
                errors++;
                $display("FAIL unexpected_done: got a=%0d b=%0d expected %0d", done_a, done_b, expect_done);
            end
        end
        if (meaningful) cmp_outputs();
    end

    task automatic feed(input string hs);
        for (int i = 0; i < hs.len(); i++) begin
            char_valid = 1'b1;
            hint_char  = hs[i];
            @(posedge clock); #1;
        end
        char_valid = 1'b0;
    endtask

    task automatic begin_session(input int key);
        @(posedge clock); #1;
        meaningful = 1'b0;
        start      = 1'b1;
        key_sel    = 2'(key);
        @(posedge clock); #1;
        start      = 1'b0;
    endtask

    task automatic run(input int key, input string hs);
        begin_session(key);
        exp_a = model(key, hs, MA);
        exp_b = model(key, hs, MB);
        feed(hs);
        hint_end = 1'b1;
        @(posedge clock); #1;
        hint_end    = 1'b0;
        expect_done = 1'b1;
        meaningful  = 1'b1;
        chk("done_latency", 192'({done_a, busy_a, done_b, busy_b}), 192'(4'b1010));
        @(posedge clock); #1;
        expect_done = 1'b0;
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        exp_t m;
        // model pins
        m = model(0, "OVERFLOW_CHECKING=OFF", 24);
        chk("pin_off_val", m.val, "OFF");
        chk("pin_off_len", 192'(m.len), 192'(3));
        m = model(1, "UNDERFLOW_CHECKING=MAYBE,UNDERFLOW_CHECKING=ON", 24);
        chk("pin_first_wins", m.val, "MAYBE");
        chk("pin_first_err", 192'(m.err), 192'(1));
        m = model(3, "", 24);
        chk("pin_default", m.val, "Stratix II");
        m = model(3, "INTENDED_DEVICE_FAMILY=Stratix II", 4);
        chk("pin_trunc", {m.val, 1'b0}, {192'("Stra"), 1'b0});
        chk("pin_trunc_err", 192'(m.err), 192'(1));
        m = model(3, " underflow_checking=ON , intended_device_family=cyclone v", 24);
        chk("pin_cyclone_val", m.val, "cyclone v");
`ifdef LPM_HINT_FAMILY_CHECK_EN
        chk("pin_cyclone_fam", 192'({m.fv, m.fs, m.fc}), 192'(3'b101));
`endif

        // reset state
        repeat (2) @(negedge clock);
        chk("reset_a", 192'({busy_a, done_a, found_a, err_a, fv_a, fs_a, fc_a, len_a}), 192'(0));
        chk("reset_val", 192'(val_a), 192'(0));
        chk("reset_b", 192'({busy_b, done_b, val_b, len_b}), 192'(0));
        aclr_n = 1'b1;

        run(0, "OVERFLOW_CHECKING=OFF");
        chk("t1_val", 192'(val_a), "OFF");
        chk("t1_len", 192'(len_a), 192'(3));
        run(3, "");
        chk("t2_val", 192'(val_a), "Stratix II");
        run(3, " underflow_checking=ON , intended_device_family=cyclone v");
        chk("t3_val", 192'(val_a), "cyclone v");
        run(1, "UNDERFLOW_CHECKING=MAYBE,UNDERFLOW_CHECKING=ON");
        chk("t4_err", 192'(err_a), 192'(1));
        run(3, "INTENDED_DEVICE_FAMILY=Foo 9000");
        run(3, "INTENDED_DEVICE_FAMILY=Stratix II");
        chk("t6_val_small", 192'(val_b), "Stra");
        run(0, "OVERFLOW_CHECKINGX=OFF,overflow_checking=  on");
        run(2, "ALLOW_RWCYCLE_WHEN_FULL");
        run(0, "OVERFLOW_CHECKING=");
        run(3, "INTENDED_DEVICE_FAMILY=  Cyclone IV E  ");
        run(1, "UNDERFLOW_CHECKING=ABCDEFGHIJKLMNOPQRSTUVWXY");
        run(0, "OVERFLOW_CHECKING=ON ");
        run(3, "=x, ,intended_device_family=MAX 10");

        // idle traffic is ignored; results stay held and no done appears
        feed("OVERFLOW_CHECKING=ON");
        hint_end = 1'b1;
        @(posedge clock); #1;
        hint_end = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // restart while busy: aborted session yields no done
        begin_session(1);
        feed("UNDERFLOW_CHECKING=OF");
        run(1, "UNDERFLOW_CHECKING=off");

        // async reset mid-hint, then a clean session
        begin_session(3);
        feed("INTENDED_DEVICE_FAMILY=Cyc");
        aclr_n = 1'b0;
        #2;
        chk("abort_a", 192'({busy_a, done_a, found_a, val_a}), 192'(0));
        chk("abort_b", 192'({busy_b, done_b, found_b, val_b}), 192'(0));
        aclr_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        run(2, "ALLOW_RWCYCLE_WHEN_FULL=ON");
        chk("t7_val", 192'(val_a), "ON");
        chk("t7_found", 192'(found_a), 192'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
